// File: rtl/csr_byte_bridge.sv
// csr_byte_bridge: turns framed byte-stream commands into single CSR bus
// accesses (read / write / set / clear) and streams back a status byte plus
// the 32-bit read data, big-endian.
module csr_byte_bridge #(
    parameter int unsigned TIMEOUT   = 1_000_000,
    parameter logic [11:0] IDLE_ADDR = 12'h000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        csr_req,
    input  logic        csr_gnt,
    output logic [11:0] csr_addr,
    output logic        csr_read,
    output logic [2:0]  csr_modify,
    output logic [31:0] csr_wdata,
    input  logic [31:0] csr_rdata,
    input  logic        csr_valid,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_ACC_A, S_ACC_E, S_ACC_M, S_RESP, S_ERR
    } state_t;

    localparam logic [31:0] TMO_LAST = TIMEOUT - 1;

    state_t      state, state_nxt;
    logic [2:0]  op_mod;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        ok_q;
    logic [2:0]  cnt;
    logic [31:0] tcnt;

    logic        rx_fire, tx_fire;
    logic        op_known;
    logic [2:0]  op_dec;
    logic        arg_last;
    logic        tmo_hit;

    assign rx_fire  = rx_valid & rx_ready;
    assign tx_fire  = tx_valid & tx_ready;
    // Read frames carry 2 argument bytes, modify frames carry 6.
    assign arg_last = (op_mod == 3'b000) ? (cnt == 3'd1) : (cnt == 3'd5);
    assign tmo_hit  = (TIMEOUT != 0) && (tcnt == TMO_LAST);

    // Opcode decode into the CSR modify encoding (read maps to 000)
    always_comb begin
        op_known = 1'b1;
        op_dec   = 3'b000;
        case (rx_data)
            8'h52:   op_dec = 3'b000;
            8'h57:   op_dec = 3'b001;
            8'h53:   op_dec = 3'b010;
            8'h43:   op_dec = 3'b011;
            default: op_known = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (rx_fire) state_nxt = op_known ? S_ARG : S_ERR;
            S_ARG: begin
                if (rx_fire) begin
                    if (arg_last) state_nxt = S_ACC_A;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ACC_A: if (csr_gnt) state_nxt = S_ACC_E;
            S_ACC_E: state_nxt = S_ACC_M;
            S_ACC_M: state_nxt = S_RESP;
            S_RESP:  if (tx_fire && cnt == 3'd4) state_nxt = S_IDLE;
            S_ERR:   if (tx_fire) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command capture, byte/timeout counters and response data capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_mod  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ok_q    <= 1'b0;
            cnt     <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_fire && op_known) begin
                        op_mod <= op_dec;
                        cnt    <= '0;
                        tcnt   <= '0;
                    end
                end
                S_ARG: begin
                    if (rx_fire) begin
                        cnt  <= cnt + 3'd1;
                        tcnt <= '0;
                        case (cnt)
                            3'd0:    addr_q[11:8] <= rx_data[3:0];
                            3'd1:    addr_q[7:0]  <= rx_data;
                            default: wdata_q      <= {wdata_q[23:0], rx_data};
                        endcase
                    end else begin
                        tcnt <= tcnt + 32'd1;
                    end
                end
                S_ACC_M: begin
                    ok_q    <= csr_valid;
                    rdata_q <= csr_rdata;
                    cnt     <= '0;
                end
                S_RESP: if (tx_fire) cnt <= cnt + 3'd1;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; all return to idle values under reset
    always_comb begin
        rx_ready   = 1'b0;
        busy       = (state != S_IDLE);
        csr_req    = 1'b0;
        csr_addr   = IDLE_ADDR;
        csr_read   = 1'b0;
        csr_modify = 3'b000;
        csr_wdata  = '0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            S_IDLE, S_ARG: rx_ready = 1'b1;
            S_ACC_A: begin
                csr_req  = 1'b1;
                csr_addr = addr_q;
            end
            S_ACC_E: begin
                csr_addr   = addr_q;
                csr_read   = 1'b1;
                csr_modify = op_mod;
                csr_wdata  = (op_mod == 3'b000) ? '0 : wdata_q;
            end
            S_ACC_M: csr_addr = addr_q;
            S_RESP: begin
                tx_valid = 1'b1;
                case (cnt)
                    3'd0:    tx_data = ok_q ? 8'h4B : 8'h45;
                    3'd1:    tx_data = rdata_q[31:24];
                    3'd2:    tx_data = rdata_q[23:16];
                    3'd3:    tx_data = rdata_q[15:8];
                    default: tx_data = rdata_q[7:0];
                endcase
            end
            S_ERR: begin
                tx_valid = 1'b1;
                tx_data  = 8'h3F;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/csr_byte_bridge.md
# csr_byte_bridge

Host-side initiator for the CSR bus. It accepts framed commands on a byte stream, typically fed by a UART receiver, and issues one CSR read, write, set or clear per command using the same three-stage addr/E/M timing the CSR responders implement. It returns a status byte and the 32-bit read data on an outgoing byte stream. It sits beside the pipeline on the CSR bus; an external arbiter grants it the bus.

## Interface
Parameters:
- `TIMEOUT`, default 1_000_000: cycles allowed between bytes of one command before the partial command is discarded; 0 disables the timeout.
- `IDLE_ADDR`, default 12'h000: value driven on `csr_addr` when no access is in progress.

Ports:
- `clk` in 1: the only clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: command byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: the bridge can accept a byte; a byte transfers on an edge where `rx_valid & rx_ready`.
- `tx_data` out 8: response byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: the sink accepts the byte; a byte transfers on an edge where `tx_valid & tx_ready`.
- `csr_req` out 1: the bridge is requesting the CSR bus.
- `csr_gnt` in 1: the arbiter grants the bus. The arbiter must keep the bus for the two cycles that follow a grant.
- `csr_addr` out 12: CSR address.
- `csr_read` out 1: read strobe.
- `csr_modify` out 3: 000 none, 001 write, 010 set, 011 clear.
- `csr_wdata` out 32: write data.
- `csr_rdata` in 32: OR of all responder read data.
- `csr_valid` in 1: OR of all responder valid flags.
- `busy` out 1: high in every state except IDLE.

## Operation
Command frame:
- Byte 0 is the opcode:
  - 0x52 'R': read.
  - 0x57 'W': write.
  - 0x53 'S': set.
  - 0x43 'C': clear.
- Bytes 1–2 are the address, big-endian. Address bits [11:8] come from byte1[3:0]; byte1[7:4] is ignored.
- W, S and C carry data bytes 3–6, big-endian. R has no data bytes.
- Total frame length: R is 3 bytes; W, S and C are 7 bytes.

Response frame:
- Status byte first:
  - 0x4B 'K' if `csr_valid` was sampled high.
  - 0x45 'E' if it was low (no responder at that address).
- Then `csr_rdata` as 4 bytes, big-endian. For W, S and C this is the old CSR value. On 'E' the data bytes are whatever the OR bus returned, normally 0.
- Unknown opcode: the bridge sends the single byte 0x3F '?' and returns to IDLE. The bytes that follow are parsed as a new command.

States:
- IDLE: `rx_ready`=1. A valid opcode goes to ARG; an unknown opcode goes to ERR.
- ARG: `rx_ready`=1. Collects the remaining bytes with a byte counter. After the last byte it goes to ACC_A.
- ACC_A: `csr_req`=1 and `csr_addr` is driven. It stays here until `csr_gnt`=1, then goes to ACC_E.
- ACC_E: drives `csr_read`=1, `csr_modify` from the opcode and `csr_wdata`. Always goes to ACC_M.
- ACC_M: captures `csr_valid` and `csr_rdata` at the end of this cycle. Goes to RESP.
- RESP: sends 5 bytes, then goes to IDLE.
- ERR: sends 0x3F, then goes to IDLE.

Output rules:
- `rx_ready`=0 in ACC_A, ACC_E, ACC_M, RESP and ERR. Incoming bytes are back-pressured, never dropped.
- Outside ACC_E: `csr_read`=0, `csr_modify`=000, `csr_wdata`=0.
- Outside ACC_A, ACC_E and ACC_M: `csr_addr`=`IDLE_ADDR`. Inside those states it holds the command address.
- For R, `csr_modify`=000 in ACC_E.

Timeout:
- Active only in ARG. The counter reloads on every accepted byte.
- Reaching `TIMEOUT` idle cycles returns the bridge to IDLE silently, with no response byte.

Reset:
- While `rstn`=0, asynchronously: state IDLE, `rx_ready`=1, `tx_valid`=0, `tx_data`=0, `csr_req`=0, `csr_read`=0, `csr_modify`=000, `csr_wdata`=0, `csr_addr`=`IDLE_ADDR`, `busy`=0. Counters are cleared.
- Reset in the middle of a frame discards the frame. Reset during ACC_E removes `modify`, so no write is issued.

## Timing
- The last command byte is accepted on edge k. ACC_A is active in cycle k+1 with `csr_req`=1 and `csr_addr` valid.
- With `csr_gnt`=1 in cycle k+1:
  - Cycle k+2: ACC_E, with read, modify and wdata valid.
  - Cycle k+3: ACC_M; responder data is sampled.
  - Cycle k+4: `tx_valid`=1 with the status byte.
- Each cycle `csr_gnt`=0 in ACC_A adds one cycle of delay. The address is held stable throughout.
- Response bytes:
  - `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
  - With `tx_ready` held at 1, one byte is sent per cycle and `tx_valid` stays high for exactly 5 cycles.
  - After the edge that transfers the last byte, `rx_ready`=1 in the following cycle.
- An unknown opcode is accepted on edge k; `tx_valid`=1 with 0x3F in cycle k+1.

## Test plan
- Read: send 52 0F C0; the responder model returns valid with 0x00002EE0. Required: `csr_addr`=0xFC0 in ACC_A; `csr_read`=1 and `modify`=000 in ACC_E; tx bytes 4B 00 00 2E E0; `tx_valid` high exactly 4 cycles after the edge that accepts the last byte.
- Write, set and clear:
  - Write: send 57 0B C1 00 00 00 0A with the responder holding 0x3. Required: `modify`=001 and `wdata`=0x0000000A in ACC_E; response 4B 00 00 00 03.
  - Set and clear: repeat with 53 and 43. Required: `modify`=010 and 011 respectively.
- Unmapped address and backpressure: send 52 01 23 with no responder. Required: response 45 00 00 00 00. With `tx_ready` toggling 1/0, each byte is held stable until it transfers, and `rx_ready`=0 until the frame completes.
- Grant stall: hold `csr_gnt`=0 for 5 cycles. Required: `csr_req`=1 and `csr_addr` stable for all 5 cycles; no E cycle occurs before the grant.
- Bad opcode and timeout (`TIMEOUT`=16):
  - Send 41. Required: 3F is sent.
  - Then send 57 0B, idle for 16 cycles, then 52 0F C0. Required: only the read response is produced and no write is issued.
- Reset: assert `rstn`=0 during the third response byte. Required: all outputs are at their reset values immediately. After release, a fresh read command completes correctly.
